// File: rtl/bram_dma_arbiter_if.sv
// Shared DMA read-port bundle: requester-side level handshake plus the single DMA master port.
// slave is the arbiter's view; master is the loaders/DMA side that drives requests and returns data.
interface bram_dma_arbiter_if #(
   parameter int NUM_REQ      = 2,
   parameter int GRANT_WID    = 1,
   parameter int RAM_WID      = 32,
   parameter int RAM_WORD_WID = 16
);
   logic [NUM_REQ*RAM_WID-1:0] req_addr;
   logic [NUM_REQ-1:0]         req_read;
   logic [RAM_WORD_WID-1:0]    req_word;
   logic [NUM_REQ-1:0]         req_valid;
   logic [RAM_WID-1:0]         ram_dma_addr;
   logic                       ram_read;
   logic [RAM_WORD_WID-1:0]    ram_word;
   logic                       ram_valid;
   logic [GRANT_WID-1:0]       grant_id;
   logic                       busy;

   modport master (
      output req_addr, req_read, ram_word, ram_valid,
      input  req_word, req_valid, ram_dma_addr, ram_read, grant_id, busy
   );

   modport slave (
      input  req_addr, req_read, ram_word, ram_valid,
      output req_word, req_valid, ram_dma_addr, ram_read, grant_id, busy
   );
endinterface

// File: rtl/bram_dma_arbiter.sv
// Round-robin arbiter sharing one DMA read port among NUM_REQ BRAM loaders,
// one word per grant, all outputs registered.
module bram_dma_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int GRANT_WID    = 1,
   parameter int RAM_WID      = 32,
   parameter int RAM_WORD_WID = 16
) (
   input logic              clk,
   input logic              rst_n,
   bram_dma_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

   state_t               state;
   logic [GRANT_WID-1:0] last_grant;
   logic [GRANT_WID-1:0] winner;
   logic [RAM_WID-1:0]   win_addr;

   // Two descending passes: the lowest requester above last_grant wins, else the
   // lowest one at or below it (the wrap-around), which gives the rotating priority.
   always_comb begin
      winner = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (bus.req_read[j] && (j <= int'(last_grant))) winner = GRANT_WID'(j);
      end
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (bus.req_read[j] && (j > int'(last_grant))) winner = GRANT_WID'(j);
      end
   end

   assign win_addr = bus.req_addr[int'(winner)*RAM_WID +: RAM_WID];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         last_grant       <= GRANT_WID'(NUM_REQ - 1);
         bus.grant_id     <= '0;
         bus.ram_dma_addr <= '0;
         bus.ram_read     <= 1'b0;
         bus.req_word     <= '0;
         bus.req_valid    <= '0;
         bus.busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A still-high ram_valid means the master has not released the previous word yet.
               if ((|bus.req_read) && !bus.ram_valid) begin
                  bus.grant_id     <= winner;
                  bus.ram_dma_addr <= win_addr;
                  bus.ram_read     <= 1'b1;
                  bus.busy         <= 1'b1;
                  state            <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.ram_valid) begin
                  bus.ram_read <= 1'b0;
                  bus.req_word <= bus.ram_word;
                  // A requester that dropped read meanwhile has aborted: its word is discarded.
                  if (bus.req_read[bus.grant_id]) begin
                     bus.req_valid <= NUM_REQ'(1) << bus.grant_id;
                  end
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               if (!bus.req_read[bus.grant_id]) begin
                  bus.req_valid <= '0;
                  last_grant    <= bus.grant_id;
                  bus.busy      <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_dma_arbiter.sv
// Bench for bram_dma_arbiter: directed scenarios plus randomized loaders and DMA latency,
// checked against a round-robin reference model and an address-derived memory image.
module tb_bram_dma_arbiter;
   localparam int N  = 2;
   localparam int GW = 1;
   localparam int AW = 32;
   localparam int WW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bram_dma_arbiter_if #(.NUM_REQ(N), .GRANT_WID(GW), .RAM_WID(AW), .RAM_WORD_WID(WW)) bus ();
   bram_dma_arbiter #(.NUM_REQ(N), .GRANT_WID(GW), .RAM_WID(AW), .RAM_WORD_WID(WW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int vectors = 0;
   int miscompares = 0;

   // Requester inputs come either from the directed tests or from the autonomous loaders.
   logic          auto_en = 1'b0;
   logic [N-1:0]  man_rd = '0;
   logic [N-1:0]  rd_auto = '0;
   logic [AW-1:0] man_ad[N];
   logic [AW-1:0] ad_auto[N];
   logic          inj_valid = 1'b0;
   logic          dma_valid = 1'b0;
   logic [WW-1:0] dma_word = '0;

   assign bus.req_read  = auto_en ? rd_auto : man_rd;
   assign bus.req_addr  = auto_en ? {ad_auto[1], ad_auto[0]} : {man_ad[1], man_ad[0]};
   assign bus.ram_valid = dma_valid | inj_valid;
   assign bus.ram_word  = dma_word;

   function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
      return a[15:0] ^ {a[7:0], a[15:8]} ^ a[31:16] ^ 16'h5A3C;
   endfunction

   function automatic int rr(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   // DMA master model: answers each ram_read with a one-cycle ram_valid pulse after a latency.
   int            dma_lat = 0;
   bit            rand_lat = 1'b0;
   bit            word_ovr = 1'b0;
   logic [WW-1:0] ovr_word = '0;
   initial begin
      int cnt;
      int cur_lat;
      bit active;
      cnt = 0; cur_lat = 0; active = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (dma_valid) begin
            dma_valid = 1'b0;
         end else if (bus.ram_read) begin
            if (!active) begin
               active  = 1'b1;
               cnt     = 0;
               cur_lat = rand_lat ? int'($urandom_range(3)) : dma_lat;
            end
            if (cnt >= cur_lat) begin
               dma_valid = 1'b1;
               dma_word  = word_ovr ? ovr_word : mem_word(bus.ram_dma_addr);
               active    = 1'b0;
            end else begin
               cnt++;
            end
         end else begin
            active = 1'b0;
         end
      end
   end

   // Autonomous loaders: hold read until valid, capture the word, drop, re-raise after a gap.
   int            gap_max = 0;
   bit            seq_mode = 1'b0;
   int            seq_len = 0;
   logic [AW-1:0] seq_base[N];
   int            gap[N];
   int            rx_cnt[N];
   logic [WW-1:0] rx[N][16];

   task automatic req_proc(input int i);
      forever begin
         @(posedge clk); #1;
         if (!auto_en) begin
            rd_auto[i] = 1'b0; gap[i] = 0; rx_cnt[i] = 0;
         end else if (rd_auto[i]) begin
            if (bus.req_valid[i]) begin
               rd_auto[i] = 1'b0;
               if (rx_cnt[i] < 16) rx[i][rx_cnt[i]] = bus.req_word;
               rx_cnt[i]++;
               gap[i] = int'($urandom_range(gap_max));
            end
         end else if (gap[i] > 0) begin
            gap[i]--;
         end else if (!seq_mode || rx_cnt[i] < seq_len) begin
            rd_auto[i] = 1'b1;
            ad_auto[i] = seq_mode ? seq_base[i] + AW'(rx_cnt[i]) : AW'($urandom);
         end
      end
   endtask
   initial req_proc(0);
   initial req_proc(1);

   // Monitor: logs each grant with the model's expected winner, and each delivered word.
   typedef struct { int id; logic [AW-1:0] addr; int exp_id; logic [AW-1:0] exp_addr; } iss_t;
   typedef struct { logic [N-1:0] vec; logic [WW-1:0] word; } dlv_t;
   iss_t iss_q[$];
   dlv_t dlv_q[$];
   bit   multi_seen = 1'b0;
   initial begin
      logic [N-1:0]    p_req, p_valid;
      logic            p_ram_read;
      logic [N*AW-1:0] p_addr;
      int              m_last;
      iss_t            ie;
      dlv_t            de;
      p_req = '0; p_valid = '0; p_ram_read = 1'b0; p_addr = '0; m_last = N - 1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_last = N - 1; p_req = '0; p_valid = '0; p_ram_read = 1'b0;
         end else begin
            if (bus.ram_read && !p_ram_read) begin
               ie.id       = int'(bus.grant_id);
               ie.addr     = bus.ram_dma_addr;
               ie.exp_id   = rr(p_req, m_last);
               ie.exp_addr = (ie.exp_id >= 0) ? p_addr[ie.exp_id*AW +: AW] : '0;
               iss_q.push_back(ie);
               if (ie.exp_id >= 0) m_last = ie.exp_id;
            end
            if ((|bus.req_valid) && !(|p_valid)) begin
               de.vec = bus.req_valid; de.word = bus.req_word;
               dlv_q.push_back(de);
            end
            if ($countones(bus.req_valid) > 1) multi_seen = 1'b1;
            p_req = bus.req_read; p_valid = bus.req_valid;
            p_ram_read = bus.ram_read; p_addr = bus.req_addr;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic do_reset();
      auto_en = 1'b0; man_rd = '0; inj_valid = 1'b0; rand_lat = 1'b0; word_ovr = 1'b0;
      dma_lat = 0; seq_mode = 1'b0; gap_max = 0;
      rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
      iss_q.delete(); dlv_q.delete(); multi_seen = 1'b0;
   endtask

   task automatic wait_valid(input int i, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (bus.req_valid[i]) begin ok = 1'b1; break; end
         tick(1);
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (!bus.busy) begin ok = 1'b1; break; end
         tick(1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tick(2);
      vectors++; if (bus.ram_dma_addr !== '0) begin miscompares++; $display("FAIL reset_addr: got %0h want 0", bus.ram_dma_addr); end
      vectors++; if (bus.ram_read !== 1'b0) begin miscompares++; $display("FAIL reset_ram_read: got %0b want 0", bus.ram_read); end
      vectors++; if (bus.req_word !== '0) begin miscompares++; $display("FAIL reset_word: got %0h want 0", bus.req_word); end
      vectors++; if (bus.req_valid !== '0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", bus.req_valid); end
      vectors++; if (bus.grant_id !== '0) begin miscompares++; $display("FAIL reset_grant: got %0h want 0", bus.grant_id); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
      rst_n = 1'b1; tick(1);
   endtask

   task automatic test_single();
      int wait_cyc;
      do_reset();
      dma_lat = 2; word_ovr = 1'b1; ovr_word = 16'hBEEF;
      man_ad[0] = 32'h1000; man_rd = 2'b01;
      tick(1);
      vectors++; if (bus.ram_read !== 1'b1) begin miscompares++; $display("FAIL single_ram_read: got %0b want 1", bus.ram_read); end
      vectors++; if (bus.ram_dma_addr !== 32'h1000) begin miscompares++; $display("FAIL single_addr: got %0h want 1000", bus.ram_dma_addr); end
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %0b want 1", bus.busy); end
      wait_cyc = 0;
      while (!bus.ram_valid && wait_cyc < 20) begin tick(1); wait_cyc++; end
      vectors++; if (wait_cyc !== 2) begin miscompares++; $display("FAIL single_dma_wait: got %0d want 2", wait_cyc); end
      tick(1);
      vectors++; if (bus.req_valid !== 2'b01) begin miscompares++; $display("FAIL single_valid: got %0b want 01", bus.req_valid); end
      vectors++; if (bus.req_word !== 16'hBEEF) begin miscompares++; $display("FAIL single_word: got %0h want beef", bus.req_word); end
      vectors++; if (bus.ram_read !== 1'b0) begin miscompares++; $display("FAIL single_ram_read_fall: got %0b want 0", bus.ram_read); end
      tick(1);
      vectors++; if (bus.req_valid !== 2'b01) begin miscompares++; $display("FAIL single_valid_hold: got %0b want 01", bus.req_valid); end
      man_rd = 2'b00; tick(1);
      vectors++; if (bus.req_valid !== 2'b00) begin miscompares++; $display("FAIL single_valid_drop: got %0b want 00", bus.req_valid); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_drop: got %0b want 0", bus.busy); end
      word_ovr = 1'b0;
   endtask

   task automatic test_simultaneous();
      bit ok;
      int cyc;
      do_reset();
      gap_max = 0; auto_en = 1'b1;
      cyc = 0;
      while (dlv_q.size() < 6 && cyc < 300) begin tick(1); cyc++; end
      auto_en = 1'b0; wait_idle(ok);
      vectors++; if (dlv_q.size() < 6 || !ok) begin miscompares++; $display("FAIL simul_progress: got %0d words want 6", dlv_q.size()); end
      vectors++; if (multi_seen !== 1'b0) begin miscompares++; $display("FAIL simul_onehot: got multi-valid want none"); end
      for (int k = 0; k < 4 && k < dlv_q.size(); k++) begin
         vectors++; if (iss_q[k].id !== (k % 2)) begin miscompares++; $display("FAIL simul_grant[%0d]: got %0d want %0d", k, iss_q[k].id, k % 2); end
         vectors++; if (iss_q[k].addr !== iss_q[k].exp_addr) begin miscompares++; $display("FAIL simul_addr[%0d]: got %0h want %0h", k, iss_q[k].addr, iss_q[k].exp_addr); end
         vectors++; if (dlv_q[k].vec !== (N'(1) << (k % 2))) begin miscompares++; $display("FAIL simul_vec[%0d]: got %0b want %0b", k, dlv_q[k].vec, N'(1) << (k % 2)); end
         vectors++; if (dlv_q[k].word !== mem_word(iss_q[k].addr)) begin miscompares++; $display("FAIL simul_word[%0d]: got %0h want %0h", k, dlv_q[k].word, mem_word(iss_q[k].addr)); end
      end
   endtask

   task automatic test_fairness();
      bit ok;
      do_reset();
      man_ad[0] = 32'h100; man_ad[1] = 32'h200;
      man_rd = 2'b10; tick(1);
      vectors++; if (bus.grant_id !== 1'b1) begin miscompares++; $display("FAIL fair_first: got %0d want 1", bus.grant_id); end
      wait_valid(1, ok); man_rd = 2'b00; wait_idle(ok);
      man_rd = 2'b11; tick(1);
      vectors++; if (bus.grant_id !== 1'b0) begin miscompares++; $display("FAIL fair_next: got %0d want 0", bus.grant_id); end
      vectors++; if (bus.ram_dma_addr !== 32'h100) begin miscompares++; $display("FAIL fair_addr: got %0h want 100", bus.ram_dma_addr); end
      wait_valid(0, ok);
      vectors++; if (!ok || bus.req_valid !== 2'b01) begin miscompares++; $display("FAIL fair_valid: got %0b want 01", bus.req_valid); end
      man_rd = 2'b00; wait_idle(ok);
   endtask

   task automatic test_abort();
      bit ok;
      bit bad_valid;
      int cyc;
      do_reset();
      dma_lat = 3; man_ad[0] = 32'h3000; man_rd = 2'b01;
      tick(1); tick(1);
      man_rd = 2'b00;
      bad_valid = 1'b0; cyc = 0;
      while (!bus.ram_valid && cyc < 20) begin bad_valid |= (|bus.req_valid); tick(1); cyc++; end
      vectors++; if (bus.ram_valid !== 1'b1) begin miscompares++; $display("FAIL abort_dma_done: got %0b want 1", bus.ram_valid); end
      tick(1);
      vectors++; if (bus.ram_read !== 1'b0) begin miscompares++; $display("FAIL abort_ram_read: got %0b want 0", bus.ram_read); end
      vectors++; if (bus.req_valid !== 2'b00) begin miscompares++; $display("FAIL abort_valid: got %0b want 00", bus.req_valid); end
      wait_idle(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL abort_idle: got busy=%0b want 0", bus.busy); end
      repeat (3) begin bad_valid |= (|bus.req_valid); tick(1); end
      vectors++; if (bad_valid !== 1'b0 || dlv_q.size() != 0) begin miscompares++; $display("FAIL abort_no_valid: got %0d deliveries want 0", dlv_q.size()); end
   endtask

   task automatic test_ignore_valid();
      bit ok;
      do_reset();
      man_ad[0] = 32'h0042; inj_valid = 1'b1; man_rd = 2'b01;
      tick(2);
      vectors++; if (bus.ram_read !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL held_off: got ram_read=%0b busy=%0b want 0 0", bus.ram_read, bus.busy); end
      inj_valid = 1'b0; tick(1);
      vectors++; if (bus.ram_read !== 1'b1) begin miscompares++; $display("FAIL held_release: got %0b want 1", bus.ram_read); end
      wait_valid(0, ok);
      vectors++; if (!ok || bus.req_word !== mem_word(32'h0042)) begin miscompares++; $display("FAIL held_word: got %0h want %0h", bus.req_word, mem_word(32'h0042)); end
      man_rd = 2'b00; wait_idle(ok);
   endtask

   task automatic test_async_reset();
      bit ok;
      do_reset();
      dma_lat = 10; man_ad[1] = 32'h4444; man_rd = 2'b10;
      tick(1);
      #1 rst_n = 1'b0;
      #1;
      vectors++; if (bus.ram_read !== 1'b0) begin miscompares++; $display("FAIL areset_ram_read: got %0b want 0", bus.ram_read); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %0b want 0", bus.busy); end
      vectors++; if (bus.grant_id !== 1'b0) begin miscompares++; $display("FAIL areset_grant: got %0d want 0", bus.grant_id); end
      vectors++; if (bus.req_valid !== 2'b00) begin miscompares++; $display("FAIL areset_valid: got %0b want 00", bus.req_valid); end
      @(posedge clk); #2;
      rst_n = 1'b1; dma_lat = 0; man_ad[0] = 32'h5555; man_rd = 2'b11;
      tick(1);
      vectors++; if (bus.grant_id !== 1'b0) begin miscompares++; $display("FAIL areset_prio: got %0d want 0", bus.grant_id); end
      vectors++; if (bus.ram_dma_addr !== 32'h5555) begin miscompares++; $display("FAIL areset_addr: got %0h want 5555", bus.ram_dma_addr); end
      wait_valid(0, ok); man_rd = 2'b00; wait_idle(ok);
   endtask

   task automatic test_two_loaders();
      bit ok;
      int cyc;
      logic [WW-1:0] lo, hi;
      logic [23:0] got, exp;
      do_reset();
      seq_mode = 1'b1; seq_len = 8; seq_base[0] = 32'h0; seq_base[1] = 32'h100;
      gap_max = 2; rand_lat = 1'b1; auto_en = 1'b1;
      cyc = 0;
      while ((rx_cnt[0] < 8 || rx_cnt[1] < 8) && cyc < 600) begin tick(1); cyc++; end
      for (int i = 0; i < N; i++) begin
         vectors++; if (rx_cnt[i] !== 8) begin miscompares++; $display("FAIL loader%0d_done: got %0d words want 8", i, rx_cnt[i]); end
         for (int k = 0; k < 4; k++) begin
            lo = mem_word(seq_base[i] + AW'(2*k)); hi = mem_word(seq_base[i] + AW'(2*k + 1));
            exp = {hi[7:0], lo};
            got = {rx[i][2*k+1][7:0], rx[i][2*k]};
            vectors++; if (got !== exp) begin miscompares++; $display("FAIL loader%0d_buf[%0d]: got %0h want %0h", i, k, got, exp); end
         end
      end
      vectors++; if (multi_seen !== 1'b0) begin miscompares++; $display("FAIL loader_onehot: got multi-valid want none"); end
      auto_en = 1'b0; rand_lat = 1'b0; seq_mode = 1'b0; wait_idle(ok);
   endtask

   task automatic test_random();
      bit ok;
      int cyc;
      do_reset();
      gap_max = 3; rand_lat = 1'b1; auto_en = 1'b1;
      cyc = 0;
      while (dlv_q.size() < 30 && cyc < 2000) begin tick(1); cyc++; end
      auto_en = 1'b0; wait_idle(ok);
      vectors++; if (dlv_q.size() < 30 || !ok) begin miscompares++; $display("FAIL rand_progress: got %0d words want 30", dlv_q.size()); end
      vectors++; if (multi_seen !== 1'b0) begin miscompares++; $display("FAIL rand_onehot: got multi-valid want none"); end
      for (int k = 0; k < dlv_q.size() && k < iss_q.size(); k++) begin
         vectors++; if (iss_q[k].id !== iss_q[k].exp_id) begin miscompares++; $display("FAIL rand_grant[%0d]: got %0d want %0d", k, iss_q[k].id, iss_q[k].exp_id); end
         vectors++; if (iss_q[k].addr !== iss_q[k].exp_addr) begin miscompares++; $display("FAIL rand_addr[%0d]: got %0h want %0h", k, iss_q[k].addr, iss_q[k].exp_addr); end
         vectors++; if (dlv_q[k].vec !== (N'(1) << iss_q[k].exp_id)) begin miscompares++; $display("FAIL rand_vec[%0d]: got %0b want %0b", k, dlv_q[k].vec, N'(1) << iss_q[k].exp_id); end
         vectors++; if (dlv_q[k].word !== mem_word(iss_q[k].exp_addr)) begin miscompares++; $display("FAIL rand_word[%0d]: got %0h want %0h", k, dlv_q[k].word, mem_word(iss_q[k].exp_addr)); end
      end
      rand_lat = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         man_ad[i] = '0; ad_auto[i] = '0; seq_base[i] = '0;
      end
      test_reset();
      test_single();
      test_simultaneous();
      test_fairness();
      test_abort();
      test_ignore_valid();
      test_async_reset();
      test_two_loaders();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
